edge_detector: RTL and testbench

//  Synchronous edge detector for one single-bit level signal.
//  - Emits a one-clock pulse on RISING_EDGE for each 0->1 transition of SIGNAL.
//  - Emits a one-clock pulse on FALLING_EDGE for each 1->0 transition of SIGNAL.
//  - SIGNAL may be asynchronous to CLK; it is synchronised internally.
//  - ENABLE gates both outputs.
//  - Used wherever a level input (button, strobe, flag) must become a single-cycle event.

---
 rtl/edge_detector_pkg.sv | 19 +
 rtl/signal_synchronizer.sv | 25 ++
 rtl/edge_detector.sv | 51 +++++
 tb/tb_edge_detector.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/edge_detector_pkg.sv
// Shared constants and the edge-decision helper for the edge detector.
package edge_detector_pkg;

  localparam int   SYNC_STAGES_MAX    = 4;
  localparam logic INIT_LEVEL_DEFAULT = 1'b0;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  function automatic edge_t detect_edges(input logic s, input logic prev, input logic en);
    edge_t e;
    e.rise = en &  s & ~prev;
    e.fall = en & ~s &  prev;
    return e;
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// N-flop synchroniser for one level signal; every stage resets to INIT.
module signal_synchronizer #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{INIT}};
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// Synchronised rising/falling edge detector with registered, enable-gated one-cycle pulses.
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = INIT_LEVEL_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  input  logic SIGNAL,
  output logic RISING_EDGE,
  output logic FALLING_EDGE
);

  generate
    if (SYNC_STAGES < 1 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("edge_detector: SYNC_STAGES must be in 1..%0d", SYNC_STAGES_MAX);
    end
  endgenerate

  logic  sig_s;
  logic  prev_q;
  edge_t edge_d;

  signal_synchronizer #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT_LEVEL)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (SIGNAL),
    .q     (sig_s)
  );

  // prev keeps tracking while disabled, so re-enabling cannot fire on an old transition
  assign edge_d = detect_edges(sig_s, prev_q, ENABLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prev_q       <= INIT_LEVEL;
      RISING_EDGE  <= 1'b0;
      FALLING_EDGE <= 1'b0;
    end else begin
      prev_q       <= sig_s;
      RISING_EDGE  <= edge_d.rise;
      FALLING_EDGE <= edge_d.fall;
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: literal pulse windows plus a per-cycle history model.
module tb_edge_detector;

  localparam int   S    = 2;
  localparam logic INIT = 1'b0;

  logic free_running_clk = 1'b0;
  logic RESET  = 1'b0;
  logic ENABLE = 1'b1;
  logic SIGNAL = 1'b0;
  logic RISING_EDGE, FALLING_EDGE;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #10 free_running_clk = ~free_running_clk;

  edge_detector #(.SYNC_STAGES(S), .INIT_LEVEL(INIT)) dut (
    .CLK          (free_running_clk),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .SIGNAL       (SIGNAL),
    .RISING_EDGE  (RISING_EDGE),
    .FALLING_EDGE (FALLING_EDGE)
  );

  // Model: history of SIGNAL as seen at each clock edge since reset release.
  // Output after edge n reflects the transition between samples n-S-1 and n-S.
  logic sig_hist[$];
  logic m_rise = 1'b0, m_fall = 1'b0;

  function automatic logic hist_at(int idx);
    return (idx >= 0) ? sig_hist[idx] : INIT;
  endfunction

  always @(posedge free_running_clk or negedge RESET) begin
    if (!RESET) begin
      sig_hist.delete();
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      int n;
      logic cur, old;
      sig_hist.push_back(SIGNAL);
      n   = sig_hist.size() - 1;
      cur = hist_at(n - S);
      old = hist_at(n - S - 1);
      m_rise = ENABLE && (cur != old) && cur;
      m_fall = ENABLE && (cur != old) && !cur;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge free_running_clk) begin
    if (chk_on) begin
      chk("model_rise", RISING_EDGE, m_rise);
      chk("model_fall", FALLING_EDGE, m_fall);
      chk("model_excl", RISING_EDGE & FALLING_EDGE, 1'b0);
    end
  end

  task automatic at_edge();
    @(posedge free_running_clk);
    #2;
  endtask

  // n negedge samples; pulse expected only at sample index rpos / fpos (-1 = never)
  task automatic win(input int n, input int rpos, input int fpos, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge free_running_clk);
      chk({name, "_rise"}, RISING_EDGE,  logic'(i == rpos));
      chk({name, "_fall"}, FALLING_EDGE, logic'(i == fpos));
    end
  endtask

  initial begin
    at_edge();
    chk_on = 1'b1;
    // reset held with SIGNAL toggling; ends low so release is quiet
    for (int i = 0; i < 20; i++) begin
      at_edge();
      SIGNAL = ~SIGNAL;
      win(1, -1, -1, "in_reset");
    end
    SIGNAL = 1'b0;
    at_edge();
    RESET = 1'b1;
    win(6, -1, -1, "release");

    at_edge(); SIGNAL = 1'b1;
    win(6, 3, -1, "rise");
    win(10, -1, -1, "stable_hi");
    at_edge(); SIGNAL = 1'b0;
    win(6, -1, 3, "fall");

    at_edge(); ENABLE = 1'b0; SIGNAL = 1'b1;
    win(6, -1, -1, "dis_rise");
    at_edge(); SIGNAL = 1'b0;
    win(6, -1, -1, "dis_fall");
    at_edge(); SIGNAL = 1'b1;
    win(6, -1, -1, "dis_rise2");
    at_edge(); ENABLE = 1'b1;
    win(6, -1, -1, "reenable");
    at_edge(); SIGNAL = 1'b0;
    win(6, -1, 3, "reen_fall");

    // ENABLE drops just before the edge that would register the pulse
    at_edge(); SIGNAL = 1'b1;
    at_edge();
    at_edge(); ENABLE = 1'b0;
    win(4, -1, -1, "en_drop");
    at_edge(); ENABLE = 1'b1;
    at_edge(); SIGNAL = 1'b0;
    win(6, -1, 3, "fall2");

    // one-period glitch: rise then fall in consecutive cycles
    at_edge(); SIGNAL = 1'b1;
    at_edge(); SIGNAL = 1'b0;
    win(6, 2, 3, "glitch");

    // reset arriving mid-pulse must clear the output between clock edges
    at_edge(); SIGNAL = 1'b1;
    at_edge();
    at_edge();
    @(posedge free_running_clk);
    #3;
    chk("pre_reset_pulse", RISING_EDGE, 1'b1);
    RESET = 1'b0;
    #1;
    chk("async_clear", RISING_EDGE, 1'b0);
    win(3, -1, -1, "held_reset");
    at_edge(); RESET = 1'b1;
    win(6, 3, -1, "resume_rise");
    at_edge(); SIGNAL = 1'b0;
    win(6, -1, 3, "resume_fall");

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
